data_unpacker: RTL and testbench

DATA_UNPACKER -- requirements
Module: data_unpacker

---
 rtl/data_unpacker_pkg.sv | 16 +
 rtl/data_unpacker_chunk_sel.sv | 27 ++
 rtl/data_unpacker.sv | 166 ++++++++++++++++
 tb/tb_data_unpacker.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_unpacker_pkg.sv
// Shared definitions for the data unpacker: firmware encodings, defaults and FSM states.
package data_unpacker_pkg;

  localparam int unsigned MAX_CHAINS_DEFAULT = 4;
  localparam int unsigned FW_W               = 8;

  // Firmware value per chain selects the chunk width; anything else means full width
  localparam logic [FW_W-1:0] FW_SINGLE = 8'd0;
  localparam logic [FW_W-1:0] FW_MEDIUM = 8'd1;

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/data_unpacker_chunk_sel.sv
// Combinational chunk selector: extracts lanes offset..offset+len-1 of a buffer into
// lanes 0..count-1, zero-filling the rest; count is min(len, remaining).
module data_unpacker_chunk_sel #(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_W      = 4
) (
  input  logic [N*DATA_WIDTH-1:0] buffer,
  input  logic [CNT_W-1:0]        offset,
  input  logic [CNT_W-1:0]        chunk_len,
  input  logic [CNT_W-1:0]        remaining,
  output logic [N*DATA_WIDTH-1:0] chunk,
  output logic [CNT_W-1:0]        count
);

  always_comb begin
    count = (chunk_len < remaining) ? chunk_len : remaining;
    chunk = '0;
    for (int j = 0; j < int'(N); j++) begin
      // Source lane is range-guarded so a trailing partial chunk never reads past the buffer
      if ((CNT_W'(j) < count) && ((int'(offset) + j) < int'(N))) begin
        chunk[j*DATA_WIDTH +: DATA_WIDTH] = buffer[(int'(offset) + j)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/data_unpacker.sv
// Splits an accepted packed vector into a sequence of chunks whose width is chosen
// per chain by a small firmware table; chunks leave through registered outputs.
module data_unpacker
  import data_unpacker_pkg::*;
#(
  parameter int unsigned N                = 8,
  parameter int unsigned M                = 2,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned MAX_CHAINS       = MAX_CHAINS_DEFAULT,
  parameter logic [MAX_CHAINS*FW_W-1:0] INITIAL_FIRMWARE = '0,
  localparam int unsigned CHAIN_W = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1,
  localparam int unsigned CNT_W   = $clog2(N + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tracing,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [CHAIN_W-1:0]      chainId_in,
  input  logic [CNT_W-1:0]        count_in,
  input  logic [N*DATA_WIDTH-1:0] vector_in,
  input  logic                    config_en,
  input  logic [FW_W-1:0]         configId,
  input  logic [FW_W-1:0]         configData,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [N*DATA_WIDTH-1:0] vector_out,
  output logic [CNT_W-1:0]        count_out
);

  state_t                  state_q, state_d;
  logic [FW_W-1:0]         fw_q [MAX_CHAINS];
  logic [N*DATA_WIDTH-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]        len_q, len_d;
  logic [CNT_W-1:0]        off_q, off_d;
  logic [CNT_W-1:0]        rem_q, rem_d;
  logic                    valid_d;
  logic [N*DATA_WIDTH-1:0] vec_d;
  logic [CNT_W-1:0]        cnt_d;

  logic [FW_W-1:0]         fw_sel;
  logic [CNT_W-1:0]        in_len;
  logic [CNT_W-1:0]        in_cnt;
  logic                    last;
  logic                    accept;
  logic                    load;
  logic                    step;
  logic [N*DATA_WIDTH-1:0] src_buf;
  logic [CNT_W-1:0]        src_off;
  logic [CNT_W-1:0]        src_len;
  logic [CNT_W-1:0]        src_rem;
  logic [N*DATA_WIDTH-1:0] sel_chunk;
  logic [CNT_W-1:0]        sel_cnt;

  // Firmware table; out-of-range IDs are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(MAX_CHAINS); i++) begin
        fw_q[i] <= INITIAL_FIRMWARE[i*FW_W +: FW_W];
      end
    end else if (config_en && (32'(configId) < MAX_CHAINS)) begin
      fw_q[configId[CHAIN_W-1:0]] <= configData;
    end
  end

  assign fw_sel = (32'(chainId_in) < MAX_CHAINS) ? fw_q[chainId_in] : FW_SINGLE;
  assign in_len = (fw_sel == FW_SINGLE) ? CNT_W'(1) :
                  (fw_sel == FW_MEDIUM) ? CNT_W'(M) : CNT_W'(N);
  assign in_cnt = (count_in > CNT_W'(N)) ? CNT_W'(N) : count_in;

  // Last chunk is on the outputs once nothing remains behind it
  assign last     = (state_q == DRAIN) && (rem_q == '0);
  assign ready_in = tracing && !reset && ((state_q == EMPTY) || (last && ready_out));
  assign accept   = valid_in && ready_in;
  assign load     = accept && (in_cnt != '0);

  // A fresh vector feeds the selector directly so chunk 0 lands in the output registers
  assign src_buf = load ? vector_in : buf_q;
  assign src_off = load ? '0        : off_q;
  assign src_len = load ? in_len    : len_q;
  assign src_rem = load ? in_cnt    : rem_q;

  data_unpacker_chunk_sel #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_chunk_sel (
    .buffer    (src_buf),
    .offset    (src_off),
    .chunk_len (src_len),
    .remaining (src_rem),
    .chunk     (sel_chunk),
    .count     (sel_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    len_d   = len_q;
    off_d   = off_q;
    rem_d   = rem_q;
    valid_d = valid_out;
    vec_d   = vector_out;
    cnt_d   = count_out;
    step    = 1'b0;

    case (state_q)
      EMPTY: begin
        if (load) begin
          state_d = DRAIN;
          step    = 1'b1;
        end
      end
      DRAIN: begin
        if (valid_out && ready_out) begin
          if (!last || load) begin
            step = 1'b1;
          end else begin
            state_d = EMPTY;
            valid_d = 1'b0;
            vec_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = EMPTY;
    endcase

    // Present the selected chunk and advance the read pointer past it
    if (step) begin
      buf_d   = src_buf;
      len_d   = src_len;
      off_d   = src_off + src_len;
      rem_d   = src_rem - sel_cnt;
      valid_d = 1'b1;
      vec_d   = sel_chunk;
      cnt_d   = sel_cnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q      <= '0;
      len_q      <= '0;
      off_q      <= '0;
      rem_q      <= '0;
      valid_out  <= 1'b0;
      vector_out <= '0;
      count_out  <= '0;
    end else begin
      buf_q      <= buf_d;
      len_q      <= len_d;
      off_q      <= off_d;
      rem_q      <= rem_d;
      valid_out  <= valid_d;
      vector_out <= vec_d;
      count_out  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_data_unpacker.sv
// Randomized and directed bench for data_unpacker with a chunk-list reference model
// feeding a scoreboard queue that an independent output monitor drains.
module tb_data_unpacker;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int NC = 4;
  localparam int CW = 4;

  typedef struct {
    logic [N*DW-1:0] v;
    logic [CW-1:0]   c;
  } exp_t;

  logic            clk;
  logic            reset;
  logic            tracing;
  logic            valid_in;
  logic            ready_in;
  logic [1:0]      chainId_in;
  logic [CW-1:0]   count_in;
  logic [N*DW-1:0] vector_in;
  logic            config_en;
  logic [7:0]      configId;
  logic [7:0]      configData;
  logic            valid_out;
  logic            ready_out;
  logic [N*DW-1:0] vector_out;
  logic [CW-1:0]   count_out;

  exp_t       q[$];
  logic [7:0] fw_m [NC];
  int         checks   = 0;
  int         failures = 0;
  bit         started  = 0;

  data_unpacker #(
    .N          (N),
    .M          (2),
    .DATA_WIDTH (DW),
    .MAX_CHAINS (NC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tracing    (tracing),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .chainId_in (chainId_in),
    .count_in   (count_in),
    .vector_in  (vector_in),
    .config_en  (config_en),
    .configId   (configId),
    .configData (configData),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .vector_out (vector_out),
    .count_out  (count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: split the first min(count,N) lanes into chunks of the chain's width
  function automatic void push_model(input logic [1:0] chain, input logic [CW-1:0] cnt_in,
                                     input logic [N*DW-1:0] vec);
    int   l;
    int   cnt;
    int   n;
    exp_t e;
    case (fw_m[chain])
      8'd0:    l = 1;
      8'd1:    l = 2;
      default: l = N;
    endcase
    cnt = (int'(cnt_in) > N) ? N : int'(cnt_in);
    for (int s = 0; s < cnt; s += l) begin
      n   = (cnt - s < l) ? cnt - s : l;
      e.v = '0;
      for (int j = 0; j < n; j++) e.v[j*DW +: DW] = vec[(s+j)*DW +: DW];
      e.c = CW'(n);
      q.push_back(e);
    end
  endfunction

  // Output monitor: whenever chunks are owed the DUT must present the oldest one
  always @(negedge clk) begin
    if (started && !reset) begin
      chk("valid_out", valid_out, q.size() != 0);
      if (q.size() != 0) begin
        chk("vector_out", vector_out, q[0].v);
        chk("count_out", count_out, q[0].c);
        if (ready_out) void'(q.pop_front());
      end
    end
  end

  // Called at posedge+1 with inputs set; runs the input-side model after the monitor
  task automatic tick();
    bit exp_rdy;
    #6;
    if (!reset) begin
      exp_rdy = tracing && (q.size() == 0);
      chk("ready_in", ready_in, exp_rdy);
      if (valid_in && exp_rdy) push_model(chainId_in, count_in, vector_in);
      if (config_en && configId < NC) fw_m[configId[1:0]] = configData;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    valid_in  = 1'b0;
    config_en = 1'b0;
    ready_out = 1'b1;
    tracing   = 1'b1;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d chunks pending expected 0", q.size());
      q.delete();
    end
    tick();
  endtask

  task automatic send(input logic [1:0] chain, input logic [CW-1:0] cnt, input logic [N*DW-1:0] vec);
    valid_in   = 1'b1;
    chainId_in = chain;
    count_in   = cnt;
    vector_in  = vec;
    tick();
    valid_in   = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] id, input logic [7:0] data);
    config_en  = 1'b1;
    configId   = id;
    configData = data;
    tick();
    config_en  = 1'b0;
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_count_out", count_out, 0);
    chk("rst_vector_out", vector_out, 0);
    chk("rst_ready_in", ready_in, 0);
    q.delete();
    for (int i = 0; i < NC; i++) fw_m[i] = 8'd0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic logic [N*DW-1:0] seq_vec(input int start);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(start + i);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] rand_vec();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    tracing    = 1'b1;
    valid_in   = 1'b0;
    chainId_in = '0;
    count_in   = '0;
    vector_in  = '0;
    config_en  = 1'b0;
    configId   = '0;
    configData = '0;
    ready_out  = 1'b1;
    for (int i = 0; i < NC; i++) fw_m[i] = 8'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("init_valid_out", valid_out, 0);
    chk("init_count_out", count_out, 0);
    chk("init_vector_out", vector_out, 0);
    chk("init_ready_in", ready_in, 0);
    reset   = 1'b0;
    started = 1'b1;
    tick();

    // Width-1 chunks of a full vector
    send(2'd0, 4'd8, seq_vec(1));
    drain(50);

    // Width-2 chunks with a partial last chunk; lanes beyond count must not leak
    cfg(8'd1, 8'd1);
    send(2'd1, 4'd5, seq_vec(1));
    drain(50);

    // Full-width chunks back to back
    cfg(8'd2, 8'd2);
    valid_in   = 1'b1;
    chainId_in = 2'd2;
    count_in   = 4'd8;
    for (int i = 0; i < 6; i++) begin
      vector_in = rand_vec();
      tick();
    end
    drain(50);

    // Downstream stall mid-drain
    send(2'd0, 4'd8, seq_vec(100));
    tick();
    ready_out = 1'b0;
    repeat (3) tick();
    drain(50);

    // Firmware change during a drain only affects the next vector
    send(2'd0, 4'd4, seq_vec(200));
    cfg(8'd0, 8'd1);
    drain(50);
    send(2'd0, 4'd4, seq_vec(300));
    drain(50);
    send(2'd0, 4'd0, seq_vec(400));
    tick();
    tick();
    send(2'd1, 4'd12, seq_vec(500));
    drain(50);

    // Out-of-range firmware ID is ignored; tracing off blocks new vectors only
    cfg(8'd5, 8'd0);
    cfg(8'd3, 8'd1);
    send(2'd3, 4'd7, seq_vec(600));
    tracing  = 1'b0;
    valid_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vector_in = rand_vec();
      tick();
    end
    drain(50);

    // Reset mid-drain, then firmware must be back to its reset value
    send(2'd0, 4'd8, seq_vec(700));
    tick();
    do_reset();
    tick();
    send(2'd0, 4'd4, seq_vec(800));
    drain(50);

    // Random traffic with random stalls and firmware writes
    for (int i = 0; i < 400; i++) begin
      valid_in   = ($urandom_range(0, 3) != 0);
      chainId_in = 2'($urandom_range(0, 3));
      count_in   = CW'($urandom_range(0, 10));
      vector_in  = rand_vec();
      ready_out  = ($urandom_range(0, 3) != 0);
      tracing    = ($urandom_range(0, 9) != 0);
      config_en  = ($urandom_range(0, 9) == 0);
      configId   = 8'($urandom_range(0, 5));
      configData = 8'($urandom_range(0, 3));
      tick();
    end
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
